// File: rtl/px_window_3x3_pkg.sv
// Shared definitions for the 3x3 pixel window builder: pixel width ceiling,
// frame-sequencing states and window slot geometry.
package px_window_3x3_pkg;

    localparam int MAX_PIXEL_BITS = 8;

    // Window geometry: slot k = WIN_COLS*r + c, r=0 is the top (oldest) line.
    localparam int WIN_COLS   = 3;
    localparam int WIN_SLOTS  = 9;
    localparam int WIN_CENTRE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } win_state_t;

endpackage

// File: rtl/px_window_3x3_line_buffer.sv
// One image line of pixels held in registers. The read and write share the
// column address, so a read returns the value stored before this cycle's write,
// which is exactly what the window needs (previous line at the same column).
module px_window_3x3_line_buffer
    import px_window_3x3_pkg::*;
#(
    parameter int  PIXEL_BITS = MAX_PIXEL_BITS,
    parameter int  IMG_WIDTH  = 16,
    localparam int ADDR_W     = $clog2(IMG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  nreset_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [PIXEL_BITS-1:0] wr_data_i,
    output logic [PIXEL_BITS-1:0] rd_data_o
);

    logic [PIXEL_BITS-1:0] mem_q [IMG_WIDTH];
    logic [PIXEL_BITS-1:0] mem_d [IMG_WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < IMG_WIDTH; gi++) begin : g_entry
            // Next value of one entry: overwrite only when this column is addressed.
            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (wr_en_i && (addr_i == ADDR_W'(gi))) begin
                    mem_d[gi] = wr_data_i;
                end
            end

            // Entry storage, cleared by reset.
            always_ff @(posedge clk or negedge nreset_i) begin
                if (!nreset_i) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/px_window_3x3.sv
// 3x3 neighbourhood window builder for a raster-order grayscale stream.
// Two line buffers feed the right-hand column of a shifting 3x3 register array;
// a completed window is copied to win_o and strobed with win_vld_o.
// Optional build macro: PX_WINDOW_OVERRUN_FLAG_EN enables the sticky overrun_o
// flag for pixels presented outside FILL; otherwise overrun_o is tied low.
module px_window_3x3
    import px_window_3x3_pkg::*;
#(
    parameter int  PIXEL_BITS = MAX_PIXEL_BITS,
    parameter int  IMG_WIDTH  = 16,
    parameter int  IMG_HEIGHT = 16,
    localparam int ROW_W      = $clog2(IMG_HEIGHT),
    localparam int COL_W      = $clog2(IMG_WIDTH)
) (
    input  logic                      clk,
    input  logic                      nreset_i,
    input  logic                      start_i,
    input  logic                      px_rdy_i,
    input  logic [PIXEL_BITS-1:0]     px_i,
    output logic [9*PIXEL_BITS-1:0]   win_o,
    output logic                      win_vld_o,
    output logic [ROW_W-1:0]          row_o,
    output logic [COL_W-1:0]          col_o,
    output logic                      frame_done_o,
    output logic                      overrun_o
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    win_state_t            state_q, state_d;
    logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
    logic [COL_W-1:0]      col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [PIXEL_BITS-1:0] win_q [WIN_SLOTS];
    logic [PIXEL_BITS-1:0] win_d [WIN_SLOTS];
    logic [PIXEL_BITS-1:0] win_out_q [WIN_SLOTS];
    logic [PIXEL_BITS-1:0] win_out_d [WIN_SLOTS];
    logic                  win_vld_q, win_vld_d;
    logic                  frame_done_q, frame_done_d;
    logic [PIXEL_BITS-1:0] lb0_rd, lb1_rd;
    logic                  accept;

    // start_i has priority, so a pixel arriving with it is dropped.
    assign accept = (state_q == FILL) && px_rdy_i && !start_i;

    // lb0 holds the previous line, lb1 the line before it.
    px_window_3x3_line_buffer #(.PIXEL_BITS(PIXEL_BITS), .IMG_WIDTH(IMG_WIDTH)) u_lb0 (
        .clk       (clk),
        .nreset_i  (nreset_i),
        .wr_en_i   (accept),
        .addr_i    (col_cnt_q),
        .wr_data_i (px_i),
        .rd_data_o (lb0_rd)
    );

    px_window_3x3_line_buffer #(.PIXEL_BITS(PIXEL_BITS), .IMG_WIDTH(IMG_WIDTH)) u_lb1 (
        .clk       (clk),
        .nreset_i  (nreset_i),
        .wr_en_i   (accept),
        .addr_i    (col_cnt_q),
        .wr_data_i (lb0_rd),
        .rd_data_o (lb1_rd)
    );

    // Frame sequencing, position counters, window shift and output capture.
    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        col_cnt_d    = col_cnt_q;
        row_d        = row_q;
        col_d        = col_q;
        win_d        = win_q;
        win_out_d    = win_out_q;
        win_vld_d    = 1'b0;
        frame_done_d = 1'b0;

        if (start_i) begin
            state_d   = FILL;
            row_cnt_d = '0;
            col_cnt_d = '0;
            row_d     = '0;
            col_d     = '0;
        end else if (accept) begin
            row_d = row_cnt_q;
            col_d = col_cnt_q;

            // Shift every row one column left, then load the new right column.
            for (int s = 0; s < WIN_SLOTS; s++) begin
                if ((s % WIN_COLS) != (WIN_COLS - 1)) begin
                    win_d[s] = win_q[s + 1];
                end
            end
            win_d[WIN_COLS - 1]   = lb1_rd;
            win_d[WIN_CENTRE + 1] = lb0_rd;
            win_d[WIN_SLOTS - 1]  = px_i;

            // Only windows lying fully inside the image are published.
            win_vld_d = (row_cnt_q >= ROW_W'(2)) && (col_cnt_q >= COL_W'(2));
            if (win_vld_d) begin
                win_out_d = win_d;
            end

            if (col_cnt_q == COL_LAST) begin
                col_cnt_d = '0;
                if (row_cnt_q == ROW_LAST) begin
                    row_cnt_d    = '0;
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                end
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end
    end

`ifdef PX_WINDOW_OVERRUN_FLAG_EN
    logic overrun_q, overrun_d;

    // Sticky flag for pixels offered while not filling; cleared by a new frame.
    always_comb begin
        overrun_d = overrun_q;
        if (start_i) begin
            overrun_d = 1'b0;
        end else if (px_rdy_i && (state_q != FILL)) begin
            overrun_d = 1'b1;
        end
    end

    // Overrun flag register.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_o = overrun_q;
`else
    assign overrun_o = 1'b0;
`endif

    // State, counters, window array and registered outputs.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q      <= IDLE;
            row_cnt_q    <= '0;
            col_cnt_q    <= '0;
            row_q        <= '0;
            col_q        <= '0;
            win_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
            for (int s = 0; s < WIN_SLOTS; s++) begin
                win_q[s]     <= '0;
                win_out_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            col_cnt_q    <= col_cnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            win_vld_q    <= win_vld_d;
            frame_done_q <= frame_done_d;
            for (int s = 0; s < WIN_SLOTS; s++) begin
                win_q[s]     <= win_d[s];
                win_out_q[s] <= win_out_d[s];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIN_SLOTS; gi++) begin : g_win_out
            assign win_o[gi*PIXEL_BITS +: PIXEL_BITS] = win_out_q[gi];
        end
    endgenerate

    assign win_vld_o    = win_vld_q;
    assign row_o        = row_q;
    assign col_o        = col_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_px_window_3x3.sv
// Self-checking bench for px_window_3x3 on a 4x4 image.
// A frame-level model (image array + raster position) predicts every output
// each cycle; literal windows pin the model for the key scenarios.
module tb_px_window_3x3;
    import px_window_3x3_pkg::*;

    localparam int PB = 8;
    localparam int W  = 4;
    localparam int H  = 4;
`ifdef PX_WINDOW_OVERRUN_FLAG_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nreset_i = 1'b0;
    logic          start_i = 1'b0;
    logic          px_rdy_i = 1'b0;
    logic [PB-1:0] px_i = '0;
    logic [9*PB-1:0] win_o;
    logic          win_vld_o;
    logic [1:0]    row_o;
    logic [1:0]    col_o;
    logic          frame_done_o;
    logic          overrun_o;

    always #5 clk = ~clk;

    px_window_3x3 #(.PIXEL_BITS(PB), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk          (clk),
        .nreset_i     (nreset_i),
        .start_i      (start_i),
        .px_rdy_i     (px_rdy_i),
        .px_i         (px_i),
        .win_o        (win_o),
        .win_vld_o    (win_vld_o),
        .row_o        (row_o),
        .col_o        (col_o),
        .frame_done_o (frame_done_o),
        .overrun_o    (overrun_o)
    );

    int errors = 0;
    int checks = 0;

    // Model state
    int          img [W*H];
    bit          m_active;
    int          m_pos;
    logic [71:0] exp_win;
    bit          exp_vld, exp_done, exp_ovr;
    int          exp_row, exp_col;

    // Observed strobes
    logic [71:0] vld_q [$];
    bit          done_q [$];

    task automatic check(string name, logic [71:0] act, logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [71:0] pack9(input int v [9]);
        logic [71:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[k*PB +: PB] = 8'(v[k]);
        return r;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        exp_win  = '0;
        exp_vld  = 1'b0;
        exp_done = 1'b0;
        exp_ovr  = 1'b0;
        exp_row  = 0;
        exp_col  = 0;
    endtask

    task automatic model_step(bit st, bit rdy, logic [PB-1:0] px);
        int r, c;
        exp_vld  = 1'b0;
        exp_done = 1'b0;
        if (!nreset_i) begin
            model_reset();
        end else if (st) begin
            m_active = 1'b1;
            m_pos    = 0;
            exp_ovr  = 1'b0;
            exp_row  = 0;
            exp_col  = 0;
        end else if (rdy) begin
            if (m_active) begin
                r = m_pos / W;
                c = m_pos % W;
                img[m_pos] = int'(px);
                exp_row = r;
                exp_col = c;
                if (r >= 2 && c >= 2) begin
                    exp_vld = 1'b1;
                    for (int k = 0; k < 9; k++)
                        exp_win[k*PB +: PB] = 8'(img[(r - 2 + k / 3) * W + (c - 2 + k % 3)]);
                end
                if (m_pos == W*H - 1) begin
                    exp_done = 1'b1;
                    m_active = 1'b0;
                end
                m_pos++;
            end else if (OVR_EN) begin
                exp_ovr = 1'b1;
            end
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic compare_cycle();
        check("win_vld", 72'(win_vld_o), 72'(exp_vld));
        check("win", win_o, exp_win);
        check("row", 72'(row_o), 72'(exp_row));
        check("col", 72'(col_o), 72'(exp_col));
        check("frame_done", 72'(frame_done_o), 72'(exp_done));
        check("overrun", 72'(overrun_o), 72'(exp_ovr));
        if (win_vld_o) begin
            vld_q.push_back(win_o);
            $display("window %0d at t=%0t row=%0d col=%0d win=%h done=%0b",
                     vld_q.size(), $time, row_o, col_o, win_o, frame_done_o);
        end
        if (frame_done_o) done_q.push_back(win_vld_o);
    endtask

    task automatic drive(bit st, bit rdy, logic [PB-1:0] px);
        start_i  = st;
        px_rdy_i = rdy;
        px_i     = px;
        @(posedge clk);
        model_step(st, rdy, px);
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic stream(int base, int first, int count, int gap);
        for (int p = first; p < first + count; p++) begin
            drive(1'b0, 1'b1, 8'(base + p));
            for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic frame_checks(string tag, int vb, int db, logic [71:0] fw, logic [71:0] lw);
        check({tag, "_n_windows"}, 72'(vld_q.size() - vb), 72'(4));
        if (vld_q.size() >= vb + 4) begin
            check({tag, "_first_win"}, vld_q[vb], fw);
            check({tag, "_last_win"}, vld_q[vb + 3], lw);
        end
        check({tag, "_n_done"}, 72'(done_q.size() - db), 72'(1));
        if (done_q.size() > db) check({tag, "_done_aligned"}, 72'(done_q[db]), 72'(1));
    endtask

    initial begin
        int f0 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int l0 [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        int f1 [9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        int l1 [9] = '{105, 106, 107, 109, 110, 111, 113, 114, 115};
        int f2 [9] = '{8'h11, 1, 2, 4, 5, 6, 8, 9, 10};
        int vb, db;

        model_reset();
        for (int i = 0; i < W*H; i++) img[i] = 0;

        // Reset state
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        nreset_i = 1'b1;
        drive(1'b0, 1'b1, 8'h77);          // IDLE: ignored

        // Back-to-back frame 0..15
        drive(1'b1, 1'b0, 8'h00);
        vb = vld_q.size(); db = done_q.size();
        stream(0, 0, 16, 0);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        frame_checks("b2b", vb, db, pack9(f0), pack9(l0));

        // Same frame with 3 idle cycles between pixels
        drive(1'b1, 1'b0, 8'h00);
        vb = vld_q.size(); db = done_q.size();
        stream(0, 0, 16, 3);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        frame_checks("gap", vb, db, pack9(f0), pack9(l0));

        // Pixel after DONE
        drive(1'b0, 1'b1, 8'hAA);
        check("ovr_after_done", 72'(overrun_o), 72'(OVR_EN));
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        check("ovr_sticky", 72'(overrun_o), 72'(OVR_EN));
        drive(1'b1, 1'b0, 8'h00);
        check("ovr_cleared", 72'(overrun_o), 72'(0));

        // Partial frame, restart, full frame 100..115
        stream(200, 0, 6, 0);
        drive(1'b1, 1'b0, 8'h00);
        vb = vld_q.size(); db = done_q.size();
        stream(100, 0, 16, 0);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        frame_checks("restart", vb, db, pack9(f1), pack9(l1));

        // start_i with px_rdy_i: pixel 0x55 dropped, 0x11 lands at (0,0)
        drive(1'b1, 1'b1, 8'h55);
        vb = vld_q.size(); db = done_q.size();
        drive(1'b0, 1'b1, 8'h11);
        check("start_rdy_row", 72'(row_o), 72'(0));
        check("start_rdy_col", 72'(col_o), 72'(0));
        stream(0, 1, 15, 0);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        frame_checks("start_rdy", vb, db, pack9(f2), pack9(l0));

        // Asynchronous reset mid-frame
        drive(1'b1, 1'b0, 8'h00);
        stream(0, 0, 7, 0);
        #2 nreset_i = 1'b0;
        #1;
        check("rst_win", win_o, 72'(0));
        check("rst_vld", 72'(win_vld_o), 72'(0));
        check("rst_row", 72'(row_o), 72'(0));
        check("rst_col", 72'(col_o), 72'(0));
        check("rst_done", 72'(frame_done_o), 72'(0));
        check("rst_ovr", 72'(overrun_o), 72'(0));
        model_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h44);
        nreset_i = 1'b1;
        drive(1'b0, 1'b1, 8'h33);          // IDLE after reset: ignored
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        stream(0, 0, 3, 0);
        check("post_rst_col", 72'(col_o), 72'(2));
        repeat (2) drive(1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
